// File: rtl/ysyx_040729_axi_pkg.sv
// Shared definitions for the instruction-cache AXI line refill path.
// Holds the refill FSM encoding and the fixed AXI burst constants.
package ysyx_040729_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R0   = 3'd2,
    ST_R1   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         LINE_BEATS = 2;
  localparam logic [7:0] AR_LEN     = 8'(LINE_BEATS - 1);

endpackage

// File: rtl/ysyx_040729_axi_line_reader.sv
// Refill engine: one 16-byte line request becomes one two-beat AXI4 INCR read,
// returned to the instruction cache as a 128-bit line with a one-cycle ready pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a read request; write requests pulse wr_err_o
// AR      | address phase, axi_ar_valid_o held until axi_ar_ready_i
// R0      | waiting for beat 0, stored into line[63:0]
// R1      | waiting for beat 1, stored into line[127:64]
// DONE    | rw_ready_o (and rw_err_o if any beat was bad) for one cycle
module ysyx_040729_axi_line_reader
  import ysyx_040729_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [63:0]       rw_addr_i,
  input  logic              rw_req_i,
  input  logic              rw_valid_i,
  output logic [127:0]      data_read_o,
  output logic              rw_ready_o,
  output logic              rw_err_o,
  output logic              wr_err_o,
  output logic              axi_ar_valid_o,
  input  logic              axi_ar_ready_i,
  output logic [ADDR_W-1:0] axi_ar_addr_o,
  output logic [3:0]        axi_ar_id_o,
  output logic [7:0]        axi_ar_len_o,
  output logic [2:0]        axi_ar_size_o,
  output logic [1:0]        axi_ar_burst_o,
  input  logic              axi_r_valid_i,
  output logic              axi_r_ready_o,
  input  logic [63:0]       axi_r_data_i,
  input  logic [1:0]        axi_r_resp_i,
  input  logic              axi_r_last_i,
  input  logic [3:0]        axi_r_id_i
);

  state_e              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [127:0]        line_q;
  logic                err_q;
  logic                accept;
  logic                beat_fire;
  logic                beat_bad;
  logic                unused_addr_bits;

  // Only bits [ADDR_W-1:4] of the cache address reach the bus.
  assign unused_addr_bits = ^{rw_addr_i[63:ADDR_W], rw_addr_i[3:0]};

  assign accept    = (state == ST_IDLE) && rw_valid_i && !rw_req_i;
  assign beat_fire = axi_r_valid_i && axi_r_ready_o;
  // Beat 0 must not carry last, beat 1 must.
  assign beat_bad  = (axi_r_resp_i != RESP_OKAY) || (axi_r_id_i != AXI_ID) ||
                     (axi_r_last_i != (state == ST_R1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= {rw_addr_i[ADDR_W-1:4], 4'b0000};
        err_q  <= 1'b0;
      end
      if (beat_fire) begin
        err_q <= err_q | beat_bad;
        if (state == ST_R0) line_q[63:0]   <= axi_r_data_i;
        else                line_q[127:64] <= axi_r_data_i;
      end
    end
  end

  always_comb begin
    state_n        = state;
    axi_ar_valid_o = 1'b0;
    axi_r_ready_o  = 1'b0;
    rw_ready_o     = 1'b0;
    rw_err_o       = 1'b0;
    wr_err_o       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_n = ST_AR;
        wr_err_o = rw_valid_i && rw_req_i;
      end
      ST_AR: begin
        axi_ar_valid_o = 1'b1;
        if (axi_ar_ready_i) state_n = ST_R0;
      end
      ST_R0: begin
        axi_r_ready_o = 1'b1;
        if (axi_r_valid_i) state_n = ST_R1;
      end
      ST_R1: begin
        axi_r_ready_o = 1'b1;
        if (axi_r_valid_i) state_n = ST_DONE;
      end
      ST_DONE: begin
        rw_ready_o = 1'b1;
        rw_err_o   = err_q;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign data_read_o    = line_q;
  assign axi_ar_addr_o  = addr_q;
  assign axi_ar_id_o    = AXI_ID;
  assign axi_ar_len_o   = AR_LEN;
  assign axi_ar_size_o  = SIZE_8B;
  assign axi_ar_burst_o = BURST_INCR;

endmodule

// File: tb/tb_ysyx_040729_axi_line_reader.sv
// Self-checking bench for the AXI line reader: a small AXI slave with
// programmable AR/R delays and a scoreboard of expected lines.
module tb_ysyx_040729_axi_line_reader;
  import ysyx_040729_axi_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [63:0]  rw_addr_i = '0;
  logic         rw_req_i = 1'b0;
  logic         rw_valid_i = 1'b0;
  logic [127:0] data_read_o;
  logic         rw_ready_o, rw_err_o, wr_err_o;
  logic         axi_ar_valid_o;
  logic         axi_ar_ready_i = 1'b0;
  logic [31:0]  axi_ar_addr_o;
  logic [3:0]   axi_ar_id_o;
  logic [7:0]   axi_ar_len_o;
  logic [2:0]   axi_ar_size_o;
  logic [1:0]   axi_ar_burst_o;
  logic         axi_r_valid_i = 1'b0;
  logic         axi_r_ready_o;
  logic [63:0]  axi_r_data_i = '0;
  logic [1:0]   axi_r_resp_i = '0;
  logic         axi_r_last_i = 1'b0;
  logic [3:0]   axi_r_id_i = '0;

  ysyx_040729_axi_line_reader dut (
    .clock(clock), .reset(reset),
    .rw_addr_i(rw_addr_i), .rw_req_i(rw_req_i), .rw_valid_i(rw_valid_i),
    .data_read_o(data_read_o), .rw_ready_o(rw_ready_o), .rw_err_o(rw_err_o),
    .wr_err_o(wr_err_o),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_id_o(axi_ar_id_o),
    .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
    .axi_ar_burst_o(axi_ar_burst_o),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
    .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
    .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           start;
    int           lat;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // slave configuration, written only by the stimulus process
  logic [63:0] s_data [2];
  logic [1:0]  s_resp [2];
  logic        s_last [2];
  logic [3:0]  s_id   [2];
  int          s_ar_dly = 0;
  int          s_r_gap = 0;
  logic [31:0] exp_addr = '0;

  // slave state, written only by the slave process
  int ar_wait = 0;
  int gap_cnt = 0;
  int beat_idx = 0;
  bit beat_pending = 1'b0;

  always @(negedge clock) begin
    if (!reset || (!axi_ar_valid_o && !axi_r_ready_o)) begin
      beat_idx = 0;
      gap_cnt = 0;
      beat_pending = 1'b0;
    end else if (beat_pending) begin
      beat_idx++;
      gap_cnt = 0;
      beat_pending = 1'b0;
    end
    if (reset && axi_ar_valid_o) begin
      chk("ar_addr", axi_ar_addr_o, exp_addr);
      axi_ar_ready_i = (ar_wait >= s_ar_dly);
      ar_wait++;
    end else begin
      axi_ar_ready_i = 1'b0;
      ar_wait = 0;
    end
    if (reset && axi_r_ready_o && beat_idx < LINE_BEATS) begin
      if (gap_cnt >= s_r_gap) begin
        axi_r_valid_i = 1'b1;
        axi_r_data_i  = s_data[beat_idx];
        axi_r_resp_i  = s_resp[beat_idx];
        axi_r_last_i  = s_last[beat_idx];
        axi_r_id_i    = s_id[beat_idx];
        beat_pending  = 1'b1;
      end else begin
        axi_r_valid_i = 1'b0;
        gap_cnt++;
      end
    end else begin
      axi_r_valid_i = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (reset && rw_ready_o) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ready", rw_ready_o, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("line", data_read_o, mon_e.data);
        chk("rw_err", rw_err_o, mon_e.err);
        chk("latency", cyc - mon_e.start, mon_e.lat);
      end
    end
  end

  task automatic run_line(input logic [63:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [1:0] rs0, input logic [1:0] rs1,
                          input logic l0, input logic l1, input logic [3:0] i0, input logic [3:0] i1,
                          input int ard, input int rg, input logic exp_err);
    exp_t e;
    int n;
    @(negedge clock);
    s_data[0] = d0; s_data[1] = d1;
    s_resp[0] = rs0; s_resp[1] = rs1;
    s_last[0] = l0; s_last[1] = l1;
    s_id[0] = i0; s_id[1] = i1;
    s_ar_dly = ard; s_r_gap = rg;
    exp_addr = {addr[31:4], 4'h0};
    rw_addr_i = addr; rw_req_i = 1'b0; rw_valid_i = 1'b1;
    e.data = {d1, d0}; e.err = exp_err; e.start = cyc; e.lat = 4 + ard + 2 * rg;
    sb_q.push_back(e);
    n = 0;
    do begin @(negedge clock); #1; n++; end while (!rw_ready_o && n < 100);
    chk("ready_seen", rw_ready_o, 1'b1);
    @(posedge clock); #1;
    rw_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_line", data_read_o, 128'h0);
    chk("rst_ctl", {rw_ready_o, rw_err_o, wr_err_o, axi_ar_valid_o, axi_r_ready_o}, 5'b0);
    chk("rst_araddr", axi_ar_addr_o, 32'h0);
    chk("ar_len", axi_ar_len_o, 8'd1);
    chk("ar_size", axi_ar_size_o, 3'b011);
    chk("ar_burst", axi_ar_burst_o, 2'b01);
    chk("ar_id", axi_ar_id_o, 4'd0);
    @(negedge clock);
    reset = 1'b1;

    // basic zero-wait fetch, then data must hold while idle
    run_line(64'h8000_0018, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
             2'b00, 2'b00, 1'b0, 1'b1, 4'h0, 4'h0, 0, 0, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    chk("line_hold", data_read_o, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
    chk("idle_no_rready", axi_r_ready_o, 1'b0);

    // backpressure on AR and R
    run_line(64'h0000_0000_8000_1234, 64'hdead_beef_0000_0001, 64'hcafe_f00d_0000_0002,
             2'b00, 2'b00, 1'b0, 1'b1, 4'h0, 4'h0, 3, 2, 1'b0);
    // SLVERR on beat 1, then a clean back-to-back request
    run_line(64'h8000_0040, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
             2'b00, 2'b10, 1'b0, 1'b1, 4'h0, 4'h0, 0, 0, 1'b1);
    run_line(64'h8000_0050, 64'haaaa_0000_aaaa_0000, 64'hbbbb_1111_bbbb_1111,
             2'b00, 2'b00, 1'b0, 1'b1, 4'h0, 4'h0, 1, 1, 1'b0);
    // early last, missing last, wrong id, upper address bits dropped
    run_line(64'h8000_0060, 64'h1, 64'h2, 2'b00, 2'b00, 1'b1, 1'b1, 4'h0, 4'h0, 0, 0, 1'b1);
    run_line(64'h8000_0070, 64'h3, 64'h4, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 0, 1, 1'b1);
    run_line(64'h8000_0080, 64'h5, 64'h6, 2'b00, 2'b00, 1'b0, 1'b1, 4'h5, 4'h0, 2, 0, 1'b1);
    run_line(64'hffff_0000_1234_567f, 64'h7777_7777_7777_7777, 64'h9999_9999_9999_9999,
             2'b00, 2'b00, 1'b0, 1'b1, 4'h0, 4'h0, 0, 0, 1'b0);

    // write request: single wr_err_o pulse, no AR
    @(negedge clock);
    rw_addr_i = 64'h8000_0100; rw_req_i = 1'b1; rw_valid_i = 1'b1;
    #1;
    chk("wr_err_pulse", wr_err_o, 1'b1);
    chk("wr_no_ar", axi_ar_valid_o, 1'b0);
    @(negedge clock);
    #1;
    chk("wr_stays_idle", axi_ar_valid_o, 1'b0);
    rw_valid_i = 1'b0; rw_req_i = 1'b0;
    #1;
    chk("wr_err_drop", wr_err_o, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    chk("wr_no_burst", {axi_ar_valid_o, axi_r_ready_o, rw_ready_o}, 3'b0);

    // reset while in R1
    @(negedge clock);
    s_data[0] = 64'h1; s_data[1] = 64'h2;
    s_resp[0] = 2'b00; s_resp[1] = 2'b00;
    s_last[0] = 1'b0; s_last[1] = 1'b1;
    s_id[0] = 4'h0; s_id[1] = 4'h0;
    s_ar_dly = 0; s_r_gap = 3;
    exp_addr = 32'h8000_0200;
    rw_addr_i = 64'h8000_0208; rw_req_i = 1'b0; rw_valid_i = 1'b1;
    n = 0;
    do begin @(negedge clock); #1; n++; end while (!(axi_r_ready_o && beat_idx == 1) && n < 50);
    chk("reached_r1", axi_r_ready_o, 1'b1);
    reset = 1'b0;
    rw_valid_i = 1'b0;
    #1;
    chk("abort_line", data_read_o, 128'h0);
    chk("abort_ctl", {rw_ready_o, rw_err_o, wr_err_o, axi_ar_valid_o, axi_r_ready_o}, 5'b0);
    chk("abort_araddr", axi_ar_addr_o, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run_line(64'h8000_0300, 64'h0bad_f00d_1234_5678, 64'h8765_4321_d00f_dab0,
             2'b00, 2'b00, 1'b0, 1'b1, 4'h0, 4'h0, 1, 0, 1'b0);

    repeat (4) @(negedge clock);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
